// File: rtl/turn_wind_ctl.sv
// -----------------------------------------------------------------------------
// turn_wind_ctl
//
// Game-turn sequencer for the two-player artillery game. Each turn it sends a
// single-cycle next_turn request to the wind generator, waits for the new wind
// to settle, and latches it re-centred to a signed value. It then opens the aim
// window for the active player with a frame-based timeout, tracks the shot in
// flight, alternates players, and detects game over.
//
// Parameters:
//   TURN_FRAMES  frames allowed in AIM before the turn is forfeited
//   WIND_SETTLE  cycles from the next_turn pulse to the wind_signed update (>= 2)
//   WIND_CENTER  offset subtracted from the raw wind
//
// Ports:
//   clk_i            system clock
//   rst_i            asynchronous active-high reset
//   start_i          begin game pulse (honoured in IDLE and OVER only)
//   fire_i           fire pulse from the active player
//   frame_tick_i     once-per-video-frame pulse
//   shot_done_i      projectile finished pulse
//   hit_i            qualifies shot_done_i: opponent destroyed
//   wind_in_i        raw wind from the generator, 0..100
//   next_turn_o      one-cycle request to the wind generator
//   wind_signed_o    latched wind, two's complement -50..+50
//   active_player_o  0 = player 1, 1 = player 2
//   fire_enable_o    high only while aiming
//   time_left_o      remaining aim frames
//   turn_count_o     completed turns, wraps 255 -> 0
//   game_over_o      high once a hit ends the game
//   winner_o         player who scored the hit, valid with game_over_o
// -----------------------------------------------------------------------------
module turn_wind_ctl #(
   parameter int unsigned TURN_FRAMES = 600,
   parameter int unsigned WIND_SETTLE = 2,
   parameter int unsigned WIND_CENTER = 50
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic       fire_i,
   input  logic       frame_tick_i,
   input  logic       shot_done_i,
   input  logic       hit_i,
   input  logic [6:0] wind_in_i,
   output logic       next_turn_o,
   output logic [6:0] wind_signed_o,
   output logic       active_player_o,
   output logic       fire_enable_o,
   output logic [9:0] time_left_o,
   output logic [7:0] turn_count_o,
   output logic       game_over_o,
   output logic       winner_o
);

   // WIND_SETTLE >= 2, so $clog2 always yields at least one bit.
   localparam int unsigned SettleW = $clog2(WIND_SETTLE);

   // Wind is sampled one cycle before SETTLE ends so that wind_signed is valid
   // a cycle before fire_enable rises.
   localparam logic [SettleW-1:0] SettleLatch = SettleW'(WIND_SETTLE - 2);
   localparam logic [SettleW-1:0] SettleLast  = SettleW'(WIND_SETTLE - 1);
   localparam logic [9:0]         TurnFrames  = 10'(TURN_FRAMES);
   localparam logic [6:0]         WindCenter  = 7'(WIND_CENTER);

   typedef enum logic [2:0] {
      StIdle,
      StNewTurn,
      StSettle,
      StAim,
      StFlight,
      StSwap,
      StOver
   } state_e;

   state_e               state_q, state_d;
   logic [SettleW-1:0]   settle_q, settle_d;
   logic                 next_turn_q, next_turn_d;
   logic [6:0]           wind_q, wind_d;
   logic                 player_q, player_d;
   logic                 fire_en_q, fire_en_d;
   logic [9:0]           time_q, time_d;
   logic [7:0]           turns_q, turns_d;
   logic                 game_over_q, game_over_d;
   logic                 winner_q, winner_d;

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      wind_d   = wind_q;
      player_d = player_q;
      time_d   = time_q;
      turns_d  = turns_q;
      winner_d = winner_q;

      case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StNewTurn;
            end
         end

         StNewTurn: begin
            settle_d = '0;
            state_d  = StSettle;
         end

         StSettle: begin
            settle_d = settle_q + 1'b1;
            if (settle_q == SettleLatch) begin
               // Plain 7-bit wrap-around subtraction; out-of-range raw wind is not clamped.
               wind_d = wind_in_i - WindCenter;
            end
            if (settle_q == SettleLast) begin
               settle_d = '0;
               time_d   = TurnFrames;
               state_d  = StAim;
            end
         end

         StAim: begin
            // Fire beats a coincident frame tick, so the final tick cannot forfeit a shot.
            if (fire_i) begin
               state_d = StFlight;
            end else if (time_q == '0) begin
               state_d = StSwap;
            end else if (frame_tick_i) begin
               time_d = time_q - 10'd1;
               if (time_q == 10'd1) begin
                  state_d = StSwap;
               end
            end
         end

         StFlight: begin
            if (shot_done_i) begin
               if (hit_i) begin
                  winner_d = player_q;
                  state_d  = StOver;
               end else begin
                  state_d = StSwap;
               end
            end
         end

         StSwap: begin
            player_d = ~player_q;
            turns_d  = turns_q + 8'd1;
            state_d  = StNewTurn;
         end

         StOver: begin
            if (start_i) begin
               player_d = 1'b0;
               turns_d  = '0;
               state_d  = StNewTurn;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // Status outputs are registered copies of the next state.
      next_turn_d = (state_d == StNewTurn);
      fire_en_d   = (state_d == StAim);
      game_over_d = (state_d == StOver);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         settle_q    <= '0;
         next_turn_q <= 1'b0;
         wind_q      <= '0;
         player_q    <= 1'b0;
         fire_en_q   <= 1'b0;
         time_q      <= '0;
         turns_q     <= '0;
         game_over_q <= 1'b0;
         winner_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         settle_q    <= settle_d;
         next_turn_q <= next_turn_d;
         wind_q      <= wind_d;
         player_q    <= player_d;
         fire_en_q   <= fire_en_d;
         time_q      <= time_d;
         turns_q     <= turns_d;
         game_over_q <= game_over_d;
         winner_q    <= winner_d;
      end
   end

   assign next_turn_o     = next_turn_q;
   assign wind_signed_o   = wind_q;
   assign active_player_o = player_q;
   assign fire_enable_o   = fire_en_q;
   assign time_left_o     = time_q;
   assign turn_count_o    = turns_q;
   assign game_over_o     = game_over_q;
   assign winner_o        = winner_q;

endmodule

// File: tb/tb_turn_wind_ctl.sv
// -----------------------------------------------------------------------------
// tb_turn_wind_ctl
//
// Self-checking bench for turn_wind_ctl. A turn-level model (player, turn
// count, remaining frames, expected wind) is advanced by the scenario tasks
// and compared against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_turn_wind_ctl;

   localparam int unsigned TF = 600;
   localparam int unsigned WC = 50;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       fire;
   logic       frame_tick;
   logic       shot_done;
   logic       hit;
   logic [6:0] wind_in;
   logic       next_turn;
   logic [6:0] wind_signed;
   logic       active_player;
   logic       fire_enable;
   logic [9:0] time_left;
   logic [7:0] turn_count;
   logic       game_over;
   logic       winner;

   int n_checks  = 0;
   int n_fail    = 0;
   int nt_pulses = 0;

   // Turn-level reference model.
   logic       m_player;
   logic [7:0] m_turns;
   int         m_time;
   logic [6:0] m_wind;

   turn_wind_ctl #(
      .TURN_FRAMES(TF),
      .WIND_SETTLE(2),
      .WIND_CENTER(WC)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .start_i         (start),
      .fire_i          (fire),
      .frame_tick_i    (frame_tick),
      .shot_done_i     (shot_done),
      .hit_i           (hit),
      .wind_in_i       (wind_in),
      .next_turn_o     (next_turn),
      .wind_signed_o   (wind_signed),
      .active_player_o (active_player),
      .fire_enable_o   (fire_enable),
      .time_left_o     (time_left),
      .turn_count_o    (turn_count),
      .game_over_o     (game_over),
      .winner_o        (winner)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (next_turn === 1'b1) nt_pulses++;
   end

   function automatic logic [29:0] outs();
      return {next_turn, wind_signed, active_player, fire_enable, time_left, turn_count,
              game_over, winner};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_next_turn(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (next_turn === 1'b1) ok = 1'b1;
         else cyc();
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: next_turn not seen within 20 cycles, required 1", tag);
      end
   endtask

   // Called in the cycle where next_turn is high; walks through SETTLE into AIM.
   task automatic settle_turn(input logic [6:0] w);
      int d;
      int p0;
      p0 = nt_pulses;
      wind_in = w;
      d = int'(w) - int'(WC);
      m_wind = 7'(d);
      cyc();
      n_checks++;
      if (next_turn !== 1'b0 || fire_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL settle_1: next_turn=%0b fire_enable=%0b required 0 0",
                  next_turn, fire_enable);
      end
      cyc();
      n_checks++;
      if (wind_signed !== m_wind) begin
         n_fail++;
         $display("FAIL wind_latch: wind_in=%0d wind_signed=%h required %h", w, wind_signed,
                  m_wind);
      end
      n_checks++;
      if (fire_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL fire_en_early: fire_enable=%0b required 0", fire_enable);
      end
      cyc();
      m_time = TF;
      n_checks++;
      if (fire_enable !== 1'b1 || time_left !== 10'(m_time)) begin
         n_fail++;
         $display("FAIL aim_entry: fire_enable=%0b time_left=%0d required 1 %0d",
                  fire_enable, time_left, m_time);
      end
      n_checks++;
      if (nt_pulses != p0 + 1) begin
         n_fail++;
         $display("FAIL single_pulse: next_turn pulses=%0d required 1", nt_pulses - p0);
      end
   endtask

   // From AIM: random ticks, fire, ignored noise in flight, miss, next turn.
   task automatic play_turn(input int ticks, input logic [6:0] next_w);
      wind_in = 7'd77;
      for (int k = 0; k < ticks; k++) begin
         frame_tick = 1'b1;
         cyc();
         frame_tick = 1'b0;
         repeat ($urandom_range(0, 2)) cyc();
      end
      m_time = m_time - ticks;
      n_checks++;
      if (time_left !== 10'(m_time) || fire_enable !== 1'b1) begin
         n_fail++;
         $display("FAIL aim_ticks: time_left=%0d fire_enable=%0b required %0d 1",
                  time_left, fire_enable, m_time);
      end
      n_checks++;
      if (wind_signed !== m_wind) begin
         n_fail++;
         $display("FAIL wind_hold: wind_signed=%h required %h", wind_signed, m_wind);
      end
      fire = 1'b1;
      cyc();
      fire = 1'b0;
      n_checks++;
      if (fire_enable !== 1'b0 || time_left !== 10'(m_time)) begin
         n_fail++;
         $display("FAIL fire: fire_enable=%0b time_left=%0d required 0 %0d",
                  fire_enable, time_left, m_time);
      end
      begin
         int p0 = nt_pulses;
         for (int k = 0; k < 3; k++) begin
            fire       = 1'($urandom);
            frame_tick = 1'($urandom);
            start      = 1'($urandom);
            hit        = 1'b1;
            cyc();
         end
         fire = 1'b0; frame_tick = 1'b0; start = 1'b0; hit = 1'b0;
         n_checks++;
         if (time_left !== 10'(m_time) || fire_enable !== 1'b0 || game_over !== 1'b0 ||
             nt_pulses != p0) begin
            n_fail++;
            $display("FAIL flight_ignore: time_left=%0d fe=%0b go=%0b pulses=%0d required %0d 0 0 0",
                     time_left, fire_enable, game_over, nt_pulses - p0, m_time);
         end
      end
      shot_done = 1'b1;
      cyc();
      shot_done = 1'b0;
      wait_next_turn("miss_next_turn");
      m_player = ~m_player;
      m_turns  = m_turns + 8'd1;
      n_checks++;
      if (active_player !== m_player || turn_count !== m_turns) begin
         n_fail++;
         $display("FAIL swap: player=%0b turns=%0d required %0b %0d",
                  active_player, turn_count, m_player, m_turns);
      end
      settle_turn(next_w);
   endtask

   task automatic test_reset();
      int p0;
      rst = 1'b1; start = 0; fire = 0; frame_tick = 0; shot_done = 0; hit = 0; wind_in = 7'd0;
      #3;
      n_checks++;
      if (outs() !== 30'd0) begin
         n_fail++;
         $display("FAIL reset_values: outputs=%h required 0", outs());
      end
      cyc();
      rst = 1'b0;
      p0 = nt_pulses;
      for (int k = 0; k < 8; k++) begin
         fire = 1'($urandom); frame_tick = 1'($urandom); shot_done = 1'($urandom);
         hit = 1'($urandom); wind_in = 7'($urandom_range(0, 100));
         cyc();
      end
      fire = 0; frame_tick = 0; shot_done = 0; hit = 0;
      n_checks++;
      if (nt_pulses != p0 || outs() !== 30'd0) begin
         n_fail++;
         $display("FAIL idle_no_start: pulses=%0d outputs=%h required 0 0", nt_pulses - p0,
                  outs());
      end
   endtask

   task automatic test_first_turn();
      m_player = 1'b0;
      m_turns  = 8'd0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      n_checks++;
      if (next_turn !== 1'b1) begin
         n_fail++;
         $display("FAIL start_latency: next_turn=%0b required 1", next_turn);
      end
      settle_turn(7'd100);
      n_checks++;
      if (wind_signed !== 7'h32) begin
         n_fail++;
         $display("FAIL wind_max: wind_signed=%h required 32", wind_signed);
      end
   endtask

   task automatic test_random_turns();
      logic [6:0] w;
      for (int i = 0; i < 8; i++) begin
         case (i)
            0:       w = 7'd0;
            1:       w = 7'd50;
            2:       w = 7'd127;
            default: w = 7'($urandom_range(0, 100));
         endcase
         play_turn($urandom_range(0, 30), w);
      end
   endtask

   task automatic test_timeout();
      frame_tick = 1'b1;
      repeat (TF - 1) cyc();
      frame_tick = 1'b0;
      n_checks++;
      if (time_left !== 10'd1 || fire_enable !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_pre: time_left=%0d fe=%0b required 1 1", time_left, fire_enable);
      end
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      n_checks++;
      if (time_left !== 10'd0 || fire_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_expire: time_left=%0d fe=%0b required 0 0", time_left,
                  fire_enable);
      end
      wait_next_turn("timeout_next_turn");
      m_player = ~m_player;
      m_turns  = m_turns + 8'd1;
      n_checks++;
      if (active_player !== m_player || turn_count !== m_turns) begin
         n_fail++;
         $display("FAIL timeout_swap: player=%0b turns=%0d required %0b %0d",
                  active_player, turn_count, m_player, m_turns);
      end
      settle_turn(7'($urandom_range(0, 100)));
      // Fire coincident with the final tick: shot wins, no forfeit.
      frame_tick = 1'b1;
      repeat (TF - 1) cyc();
      fire = 1'b1;
      cyc();
      fire = 1'b0;
      frame_tick = 1'b0;
      n_checks++;
      if (time_left !== 10'd1 || fire_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL fire_last_tick: time_left=%0d fe=%0b required 1 0", time_left,
                  fire_enable);
      end
      begin
         int p0 = nt_pulses;
         repeat (4) cyc();
         n_checks++;
         if (nt_pulses != p0 || active_player !== m_player) begin
            n_fail++;
            $display("FAIL fire_last_no_swap: pulses=%0d player=%0b required 0 %0b",
                     nt_pulses - p0, active_player, m_player);
         end
      end
      m_time = 1;
      shot_done = 1'b1;
      cyc();
      shot_done = 1'b0;
      wait_next_turn("after_last_tick");
      m_player = ~m_player;
      m_turns  = m_turns + 8'd1;
      settle_turn(7'($urandom_range(0, 100)));
   endtask

   task automatic test_game_over();
      int p0;
      if (m_player == 1'b0) play_turn($urandom_range(0, 10), 7'($urandom_range(0, 100)));
      fire = 1'b1;
      cyc();
      fire = 1'b0;
      shot_done = 1'b1;
      hit = 1'b1;
      cyc();
      shot_done = 1'b0;
      hit = 1'b0;
      n_checks++;
      if (game_over !== 1'b1 || winner !== m_player || fire_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL game_over: go=%0b winner=%0b fe=%0b required 1 %0b 0", game_over,
                  winner, fire_enable, m_player);
      end
      p0 = nt_pulses;
      for (int k = 0; k < 5; k++) begin
         fire = 1'b1; shot_done = 1'b1; hit = 1'($urandom); frame_tick = 1'($urandom);
         cyc();
      end
      fire = 0; shot_done = 0; hit = 0; frame_tick = 0;
      n_checks++;
      if (game_over !== 1'b1 || winner !== 1'b1 || nt_pulses != p0 ||
          turn_count !== m_turns) begin
         n_fail++;
         $display("FAIL over_hold: go=%0b winner=%0b pulses=%0d turns=%0d required 1 1 0 %0d",
                  game_over, winner, nt_pulses - p0, turn_count, m_turns);
      end
      start = 1'b1;
      cyc();
      start = 1'b0;
      m_player = 1'b0;
      m_turns  = 8'd0;
      n_checks++;
      if (next_turn !== 1'b1 || game_over !== 1'b0 || active_player !== 1'b0 ||
          turn_count !== 8'd0) begin
         n_fail++;
         $display("FAIL restart: nt=%0b go=%0b player=%0b turns=%0d required 1 0 0 0",
                  next_turn, game_over, active_player, turn_count);
      end
      settle_turn(7'($urandom_range(0, 100)));
   endtask

   task automatic test_turn_wrap();
      for (int i = 0; i < 256; i++) begin
         fire = 1'b1;
         cyc();
         fire = 1'b0;
         shot_done = 1'b1;
         cyc();
         shot_done = 1'b0;
         wait_next_turn("wrap_next_turn");
         m_player = ~m_player;
         m_turns  = m_turns + 8'd1;
         settle_turn(7'($urandom_range(0, 100)));
      end
      n_checks++;
      if (turn_count !== m_turns || active_player !== m_player) begin
         n_fail++;
         $display("FAIL turn_wrap: turns=%0d player=%0b required %0d %0b", turn_count,
                  active_player, m_turns, m_player);
      end
   endtask

   task automatic test_reset_mid();
      int p0;
      // During SETTLE.
      fire = 1'b1;
      cyc();
      fire = 1'b0;
      shot_done = 1'b1;
      cyc();
      shot_done = 1'b0;
      wait_next_turn("mid_next_turn");
      cyc();
      rst = 1'b1;
      #1;
      n_checks++;
      if (outs() !== 30'd0) begin
         n_fail++;
         $display("FAIL reset_settle: outputs=%h required 0", outs());
      end
      cyc();
      rst = 1'b0;
      // During FLIGHT.
      m_player = 1'b0;
      m_turns  = 8'd0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      settle_turn(7'($urandom_range(0, 100)));
      fire = 1'b1;
      cyc();
      fire = 1'b0;
      rst = 1'b1;
      #1;
      n_checks++;
      if (outs() !== 30'd0) begin
         n_fail++;
         $display("FAIL reset_flight: outputs=%h required 0", outs());
      end
      cyc();
      rst = 1'b0;
      p0 = nt_pulses;
      for (int k = 0; k < 10; k++) begin
         fire = 1'($urandom); frame_tick = 1'($urandom); shot_done = 1'($urandom);
         hit = 1'($urandom);
         cyc();
      end
      fire = 0; frame_tick = 0; shot_done = 0; hit = 0;
      n_checks++;
      if (nt_pulses != p0 || outs() !== 30'd0) begin
         n_fail++;
         $display("FAIL post_reset_idle: pulses=%0d outputs=%h required 0 0", nt_pulses - p0,
                  outs());
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_first_turn();
      test_random_turns();
      test_timeout();
      test_game_over();
      test_turn_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
